esc_setpoint_ctrl: RTL and testbench
====================================

# esc_setpoint_ctrl

Multi-channel setpoint controller for the ESC bring-up fixture. It sits between the push-button front end (rst_synch, PB_release) and NUM_CH ESC_interface instances. It holds a per-channel speed target and offset, adjustable by inc/dec pulses on a selected channel. Each channel's SPEED output slews toward its target at a programmable rate, and OFF outputs update immediately.

## Interface
Parameters:
- NUM_CH, 4: number of ESC channels (≥1).
- SPD_W, 11: width of each SPEED field.
- OFF_W, 10: width of each OFF field.
- SPD_STEP, 128: target speed change per inc/dec pulse.
- OFF_STEP, 32: offset change per inc/dec pulse.
- RAMP_DIV, 50000: clock cycles per ramp tick (≥2).
- RAMP_STEP, 8: maximum SPEED change per ramp tick.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- inc  in  1  increment request, one-cycle pulse (from PB_release).
- dec  in  1  decrement request, one-cycle pulse.
- sel_speed  in  1  1 = inc/dec act on speed target, 0 = on offset.
- ch_sel  in  max(1,$clog2(NUM_CH))  channel addressed by inc/dec.
- zero_all  in  1  emergency stop pulse.
- SPEED  out  NUM_CH*SPD_W  per-channel slewed speed; channel k at bits [k*SPD_W +: SPD_W].
- OFF  out  NUM_CH*OFF_W  per-channel offset, same packing.
- busy  out  NUM_CH  bit k = 1 while SPEED[k] ≠ target[k].

## Operation
- Per channel: target register tgt[k] (SPD_W), SPEED register spd[k], offset register off[k]. All are unsigned.
- Command decode is evaluated each cycle. Priority order: zero_all > (inc & dec) > inc > dec.
- zero_all: tgt and spd of all channels are cleared to 0. off is unchanged. inc/dec in the same cycle are ignored.
- inc & dec in the same cycle: no change.
- inc, sel_speed=1: tgt[ch_sel] = min(tgt + SPD_STEP, 2^SPD_W−1).
- dec, sel_speed=1: tgt[ch_sel] = max(tgt − SPD_STEP, 0).
- inc/dec, sel_speed=0: off[ch_sel] is updated the same way with OFF_STEP, saturating at 2^OFF_W−1 and 0.
- Arithmetic uses one extra bit of headroom. There is never wrap-around.
- ch_sel ≥ NUM_CH: the command is ignored.
- Ramp prescaler: a free-running counter 0..RAMP_DIV−1 shared by all channels. tick = (count == RAMP_DIV−1), after which the count wraps to 0. zero_all does not reset the prescaler.
- Per-channel ramp FSM, with state derived from spd vs tgt:
  - HOLD (spd == tgt).
  - ACCEL (spd < tgt): on tick, spd = min(spd + RAMP_STEP, tgt).
  - DECEL (spd > tgt): on tick, spd = max(spd − RAMP_STEP, tgt).
- A target change mid-ramp redirects the channel from its current spd. There is no reset of ramp progress.
- busy[k] is combinational from the registered spd/tgt: busy[k] = (spd[k] ≠ tgt[k]).

## Timing
- Reset (rst_n low): tgt, spd, off and prescaler go to 0 asynchronously. Consequently SPEED=0, OFF=0, busy=0.
- inc/dec sampled at edge n: tgt/off are visible after edge n, with 1-cycle latency. busy rises in the same cycle tgt changes.
- SPEED changes only at the edge where tick=1. The first tick after reset release occurs at the RAMP_DIV-th rising edge.
- A command and a tick in the same cycle: the tick moves spd toward the old tgt; the new tgt takes effect from the next tick.
- zero_all and a tick in the same cycle: zero_all wins, and spd=0.
- Full ramp from 0 to T takes ceil(T/RAMP_STEP) ticks.

## Test plan
Bench parameters: NUM_CH=3, RAMP_DIV=4, all others at default.
- Reset: hold rst_n low, then release. Required: SPEED=0, OFF=0, busy=0; first tick on the 4th edge. Assert rst_n mid-ramp; required: all outputs drop to 0 without a clock edge.
- sel_speed=1, ch_sel=2, one inc pulse. Required:
  - tgt[2]=128 and busy[2]=1 next cycle.
  - SPEED[2] steps 8, 16, … every 4 cycles.
  - SPEED[2] reaches 128 after 16 ticks, then busy[2]=0.
  - Channels 0 and 1 stay 0.
- Saturation:
  - 16 speed incs on ch0 → tgt=2047 (the 15th gives 1920, the 16th clamps). Ramp ends at exactly 2047.
  - 32 offset incs on ch1 → OFF[1]=1023 (992 after 31).
  - dec at 0 stays 0.
- Simultaneous events:
  - inc & dec together → no change.
  - ch_sel=3 → ignored.
  - A dec issued during an ACCEL ramp from 0→256 at spd=64 → tgt=128, ramp continues up to 128.
  - A command on a tick cycle obeys the old-target rule.
- zero_all mid-ramp (spd[0]=40, tgt[0]=256, off[1]=96). Required: next cycle spd=tgt=0 on all channels, busy=0, OFF[1]=96. An inc in the same cycle is ignored.

Source files
------------

// File: rtl/esc_setpoint_ctrl.sv
// Multi-channel ESC setpoint controller: per-channel speed target and offset with
// saturating inc/dec commands, and a rate-limited SPEED slew toward each target.
module esc_setpoint_ctrl #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned SPD_W     = 11,
  parameter int unsigned OFF_W     = 10,
  parameter int unsigned SPD_STEP  = 128,
  parameter int unsigned OFF_STEP  = 32,
  parameter int unsigned RAMP_DIV  = 50000,
  parameter int unsigned RAMP_STEP = 8,
  localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      inc,
  input  logic                      dec,
  input  logic                      sel_speed,
  input  logic [CH_W-1:0]           ch_sel,
  input  logic                      zero_all,
  output logic [NUM_CH*SPD_W-1:0]   SPEED,
  output logic [NUM_CH*OFF_W-1:0]   OFF,
  output logic [NUM_CH-1:0]         busy
);

  localparam int unsigned CNT_W = $clog2(RAMP_DIV);
  localparam int unsigned SW1   = SPD_W + 1;
  localparam int unsigned OW1   = OFF_W + 1;

  localparam logic [SW1-1:0]   SPD_MAX  = {1'b0, {SPD_W{1'b1}}};
  localparam logic [SW1-1:0]   SPD_INC  = SW1'(SPD_STEP);
  localparam logic [OW1-1:0]   OFF_MAX  = {1'b0, {OFF_W{1'b1}}};
  localparam logic [OW1-1:0]   OFF_INC  = OW1'(OFF_STEP);
  localparam logic [SPD_W-1:0] RSTEP    = SPD_W'(RAMP_STEP);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAMP_DIV - 1);

  localparam logic [1:0] HOLD  = 2'd0;
  localparam logic [1:0] ACCEL = 2'd1;
  localparam logic [1:0] DECEL = 2'd2;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_c;
  logic             cmd_c;
  logic [NUM_CH-1:0] sel_hit_c;
  logic [1:0]       ramp_st_c [NUM_CH];

  logic [SPD_W-1:0] tgt_q [NUM_CH];
  logic [SPD_W-1:0] tgt_d [NUM_CH];
  logic [SPD_W-1:0] spd_q [NUM_CH];
  logic [SPD_W-1:0] spd_d [NUM_CH];
  logic [OFF_W-1:0] off_q [NUM_CH];
  logic [OFF_W-1:0] off_d [NUM_CH];

  // Saturating step helpers; one bit of headroom keeps the sum from wrapping.
  function automatic logic [SPD_W-1:0] spd_up(input logic [SPD_W-1:0] v);
    logic [SW1-1:0] s;
    s = {1'b0, v} + SPD_INC;
    return (s > SPD_MAX) ? SPD_MAX[SPD_W-1:0] : s[SPD_W-1:0];
  endfunction

  function automatic logic [SPD_W-1:0] spd_dn(input logic [SPD_W-1:0] v);
    return ({1'b0, v} < SPD_INC) ? '0 : SPD_W'({1'b0, v} - SPD_INC);
  endfunction

  function automatic logic [OFF_W-1:0] off_up(input logic [OFF_W-1:0] v);
    logic [OW1-1:0] s;
    s = {1'b0, v} + OFF_INC;
    return (s > OFF_MAX) ? OFF_MAX[OFF_W-1:0] : s[OFF_W-1:0];
  endfunction

  function automatic logic [OFF_W-1:0] off_dn(input logic [OFF_W-1:0] v);
    return ({1'b0, v} < OFF_INC) ? '0 : OFF_W'({1'b0, v} - OFF_INC);
  endfunction

  assign tick_c = (cnt_q == CNT_LAST);
  assign cmd_c  = !zero_all && (inc ^ dec);

  // Channel decode; an out-of-range ch_sel matches no channel and is dropped.
  always_comb begin
    sel_hit_c = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      sel_hit_c[k] = (ch_sel == CH_W'(k));
      if (spd_q[k] < tgt_q[k])      ramp_st_c[k] = ACCEL;
      else if (spd_q[k] > tgt_q[k]) ramp_st_c[k] = DECEL;
      else                          ramp_st_c[k] = HOLD;
    end
  end

  // Ramp step uses the pre-command target; zero_all overrides everything.
  always_comb begin
    cnt_d = tick_c ? '0 : cnt_q + CNT_W'(1);
    for (int k = 0; k < NUM_CH; k++) begin
      tgt_d[k] = tgt_q[k];
      spd_d[k] = spd_q[k];
      off_d[k] = off_q[k];
      if (tick_c) begin
        case (ramp_st_c[k])
          ACCEL:   spd_d[k] = ((tgt_q[k] - spd_q[k]) > RSTEP) ? spd_q[k] + RSTEP : tgt_q[k];
          DECEL:   spd_d[k] = ((spd_q[k] - tgt_q[k]) > RSTEP) ? spd_q[k] - RSTEP : tgt_q[k];
          default: spd_d[k] = spd_q[k];
        endcase
      end
      if (zero_all) begin
        tgt_d[k] = '0;
        spd_d[k] = '0;
      end else if (cmd_c && sel_hit_c[k]) begin
        if (sel_speed) tgt_d[k] = inc ? spd_up(tgt_q[k]) : spd_dn(tgt_q[k]);
        else           off_d[k] = inc ? off_up(off_q[k]) : off_dn(off_q[k]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        tgt_q[k] <= '0;
        spd_q[k] <= '0;
        off_q[k] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      for (int k = 0; k < NUM_CH; k++) begin
        tgt_q[k] <= tgt_d[k];
        spd_q[k] <= spd_d[k];
        off_q[k] <= off_d[k];
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign SPEED[g*SPD_W +: SPD_W] = spd_q[g];
    assign OFF[g*OFF_W +: OFF_W]   = off_q[g];
    assign busy[g]                 = (spd_q[g] != tgt_q[g]);
  end

endmodule

// File: tb/tb_esc_setpoint_ctrl.sv
// Self-checking bench for esc_setpoint_ctrl: directed sequences, a vector table and
// randomized traffic against an arithmetic reference model.
module tb_esc_setpoint_ctrl;

  localparam int NUM_CH   = 3;
  localparam int SPD_W    = 11;
  localparam int OFF_W    = 10;
  localparam int RAMP_DIV = 4;
  localparam int SPD_MAXV = 2047;
  localparam int OFF_MAXV = 1023;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic inc = 1'b0, dec = 1'b0, sel_speed = 1'b0, zero_all = 1'b0;
  logic [1:0] ch_sel = 2'd0;
  logic [NUM_CH*SPD_W-1:0] SPEED;
  logic [NUM_CH*OFF_W-1:0] OFF;
  logic [NUM_CH-1:0]       busy;

  esc_setpoint_ctrl #(.NUM_CH(NUM_CH), .RAMP_DIV(RAMP_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .inc(inc), .dec(dec), .sel_speed(sel_speed),
    .ch_sel(ch_sel), .zero_all(zero_all), .SPEED(SPEED), .OFF(OFF), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int m_tgt [NUM_CH];
  int m_spd [NUM_CH];
  int m_off [NUM_CH];
  int m_cnt;

  typedef struct {
    bit i; bit d; bit s; int c; bit z;
    int e0; int e1; int e2;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int spd_o(input int k);
    return 32'(SPEED[k*SPD_W +: SPD_W]);
  endfunction

  function automatic int off_o(input int k);
    return 32'(OFF[k*OFF_W +: OFF_W]);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NUM_CH; k++) begin
      m_tgt[k] = 0; m_spd[k] = 0; m_off[k] = 0;
    end
    m_cnt = 0;
  endtask

  // Reference: ramp toward the old target first, then apply the command.
  task automatic model_edge(input bit i, input bit d, input bit s, input int c, input bit z);
    bit tick;
    tick = (m_cnt == RAMP_DIV - 1);
    m_cnt = tick ? 0 : m_cnt + 1;
    if (tick)
      for (int k = 0; k < NUM_CH; k++) begin
        if (m_spd[k] < m_tgt[k])      m_spd[k] = (m_spd[k] + 8 > m_tgt[k]) ? m_tgt[k] : m_spd[k] + 8;
        else if (m_spd[k] > m_tgt[k]) m_spd[k] = (m_spd[k] - 8 < m_tgt[k]) ? m_tgt[k] : m_spd[k] - 8;
      end
    if (z) begin
      for (int k = 0; k < NUM_CH; k++) begin
        m_tgt[k] = 0; m_spd[k] = 0;
      end
    end else if (i != d && c < NUM_CH) begin
      if (s) m_tgt[c] = i ? ((m_tgt[c] + 128 > SPD_MAXV) ? SPD_MAXV : m_tgt[c] + 128)
                          : ((m_tgt[c] < 128) ? 0 : m_tgt[c] - 128);
      else   m_off[c] = i ? ((m_off[c] + 32 > OFF_MAXV) ? OFF_MAXV : m_off[c] + 32)
                          : ((m_off[c] < 32) ? 0 : m_off[c] - 32);
    end
  endtask

  task automatic check_model();
    for (int k = 0; k < NUM_CH; k++) begin
      chk($sformatf("model SPEED[%0d]", k), spd_o(k), m_spd[k]);
      chk($sformatf("model OFF[%0d]", k), off_o(k), m_off[k]);
      chk($sformatf("model busy[%0d]", k), busy[k], (m_spd[k] != m_tgt[k]) ? 1 : 0);
    end
  endtask

  task automatic step(input bit i, input bit d, input bit s, input int c, input bit z);
    inc = i; dec = d; sel_speed = s; ch_sel = 2'(c); zero_all = z;
    @(posedge clk);
    model_edge(i, d, s, c, z);
    #1;
    check_model();
    inc = 1'b0; dec = 1'b0; zero_all = 1'b0;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; inc = 1'b0; dec = 1'b0; zero_all = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_model();
    rst_n = 1'b1;
  endtask

  // Advance until the model's channel-k speed equals v (bounded).
  task automatic run_to_spd(input int k, input int v, input int max_cyc);
    int n;
    n = 0;
    while (m_spd[k] != v && n < max_cyc) begin idle(); n++; end
    chk($sformatf("reach SPEED[%0d]=%0d", k, v), m_spd[k], v);
  endtask

  task automatic run_to_settle(input int k, input int max_cyc);
    int n;
    n = 0;
    while (m_spd[k] != m_tgt[k] && n < max_cyc) begin idle(); n++; end
    chk($sformatf("settle busy[%0d]", k), busy[k], 0);
  endtask

  task automatic align_tick();
    while (m_cnt != RAMP_DIV - 1) idle();
  endtask

  initial begin
    int peak;
    tbl[0] = '{1, 0, 0, 1, 0, 0, 32, 0};
    tbl[1] = '{1, 0, 0, 1, 0, 0, 64, 0};
    tbl[2] = '{1, 1, 0, 1, 0, 0, 64, 0};
    tbl[3] = '{0, 1, 0, 1, 0, 0, 32, 0};
    tbl[4] = '{1, 0, 0, 3, 0, 0, 32, 0};
    tbl[5] = '{0, 1, 0, 0, 0, 0, 32, 0};
    tbl[6] = '{1, 0, 0, 2, 0, 0, 32, 32};
    tbl[7] = '{1, 0, 0, 0, 1, 0, 32, 32};
    tbl[8] = '{1, 1, 1, 0, 0, 0, 32, 32};
    tbl[9] = '{0, 1, 0, 2, 0, 0, 32, 0};

    // Reset state
    do_reset();
    chk("reset SPEED", SPEED, 0);
    chk("reset OFF", OFF, 0);
    chk("reset busy", busy, 0);

    // Single inc on ch2: first tick lands on the 4th edge after release
    step(1, 0, 1, 2, 0);
    chk("inc busy[2]", busy[2], 1);
    chk("edge1 SPEED[2]", spd_o(2), 0);
    idle(); idle();
    chk("edge3 SPEED[2]", spd_o(2), 0);
    idle();
    chk("edge4 SPEED[2]", spd_o(2), 8);
    repeat (4) idle();
    chk("edge8 SPEED[2]", spd_o(2), 16);
    repeat (55) idle();
    chk("edge63 busy[2]", busy[2], 1);
    chk("edge63 SPEED[2]", spd_o(2), 120);
    idle();
    chk("edge64 SPEED[2]", spd_o(2), 128);
    chk("edge64 busy[2]", busy[2], 0);
    chk("ch0 SPEED", spd_o(0), 0);
    chk("ch1 SPEED", spd_o(1), 0);

    // Command vector table (offset path, ignored commands, zero_all)
    for (int v = 0; v < 10; v++) begin
      step(tbl[v].i, tbl[v].d, tbl[v].s, tbl[v].c, tbl[v].z);
      chk($sformatf("tbl%0d OFF[0]", v), off_o(0), tbl[v].e0);
      chk($sformatf("tbl%0d OFF[1]", v), off_o(1), tbl[v].e1);
      chk($sformatf("tbl%0d OFF[2]", v), off_o(2), tbl[v].e2);
    end

    // Saturation
    do_reset();
    repeat (15) step(1, 0, 1, 0, 0);
    run_to_settle(0, 1200);
    chk("15 incs SPEED[0]", spd_o(0), 1920);
    step(1, 0, 1, 0, 0);
    chk("16th inc busy[0]", busy[0], 1);
    run_to_settle(0, 200);
    chk("clamped SPEED[0]", spd_o(0), 2047);
    step(1, 0, 1, 0, 0);
    chk("inc at max busy[0]", busy[0], 0);
    repeat (31) step(1, 0, 0, 1, 0);
    chk("31 off incs", off_o(1), 992);
    step(1, 0, 0, 1, 0);
    chk("32 off incs", off_o(1), 1023);
    step(1, 0, 0, 1, 0);
    chk("off inc at max", off_o(1), 1023);
    step(0, 1, 1, 1, 0);
    chk("spd dec at 0 busy[1]", busy[1], 0);
    step(0, 1, 0, 2, 0);
    chk("off dec at 0", off_o(2), 0);

    // Dec during an ACCEL ramp 0->256 at spd=64
    do_reset();
    step(1, 0, 1, 0, 0);
    step(1, 0, 1, 0, 0);
    run_to_spd(0, 64, 100);
    chk("mid ramp SPEED[0]", spd_o(0), 64);
    step(0, 1, 1, 0, 0);
    peak = 0;
    for (int n = 0; n < 200 && busy[0]; n++) begin
      idle();
      if (spd_o(0) > peak) peak = spd_o(0);
    end
    chk("redirect peak", peak, 128);
    chk("redirect final", spd_o(0), 128);
    chk("redirect busy", busy[0], 0);

    // Command on a tick edge: the tick still moves toward the old target
    do_reset();
    step(1, 0, 1, 0, 0);
    run_to_spd(0, 16, 100);
    align_tick();
    step(0, 1, 1, 0, 0);
    chk("tick+cmd SPEED[0]", spd_o(0), 24);
    chk("tick+cmd busy[0]", busy[0], 1);
    repeat (4) idle();
    chk("next tick SPEED[0]", spd_o(0), 16);
    run_to_settle(0, 100);
    chk("decel final", spd_o(0), 0);

    // zero_all mid-ramp, on a tick edge, with a same-cycle inc
    do_reset();
    repeat (3) step(1, 0, 0, 1, 0);
    step(1, 0, 1, 0, 0);
    step(1, 0, 1, 0, 0);
    run_to_spd(0, 40, 100);
    align_tick();
    step(1, 0, 1, 0, 1);
    chk("zero SPEED", SPEED, 0);
    chk("zero busy", busy, 0);
    chk("zero OFF[1]", off_o(1), 96);
    repeat (4) idle();
    chk("after zero SPEED", SPEED, 0);

    // Asynchronous reset mid-ramp
    do_reset();
    step(1, 0, 0, 0, 0);
    step(1, 0, 1, 2, 0);
    run_to_spd(2, 24, 100);
    #1 rst_n = 1'b0;
    #1;
    chk("async SPEED", SPEED, 0);
    chk("async OFF", OFF, 0);
    chk("async busy", busy, 0);
    do_reset();

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      bit ri, rd, rz;
      ri = ($urandom_range(0, 2) == 0);
      rd = ($urandom_range(0, 4) == 0);
      rz = ($urandom_range(0, 99) < 2);
      step(ri, rd, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), rz);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
